// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Opcodes, functs, ALU control codes and the control bundle that is
//            carried down the pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int RW_W  = 5;
    localparam int ALU_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [ALU_W-1:0] ALUCTR_AND  = 3'd0;
    localparam logic [ALU_W-1:0] ALUCTR_OR   = 3'd1;
    localparam logic [ALU_W-1:0] ALUCTR_ADD  = 3'd2;
    localparam logic [ALU_W-1:0] ALUCTR_SLT  = 3'd3;
    localparam logic [ALU_W-1:0] ALUCTR_ADDU = 3'd4;
    localparam logic [ALU_W-1:0] ALUCTR_SLL  = 3'd5;
    localparam logic [ALU_W-1:0] ALUCTR_SUB  = 3'd6;
    localparam logic [ALU_W-1:0] ALUCTR_SLTU = 3'd7;

    // One-hot branch kind inside ctrl_t.br
    localparam int BR_EQ  = 0;
    localparam int BR_NE  = 1;
    localparam int BR_GTZ = 2;

    typedef struct packed {
        logic             reg_dst;
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctr;
        logic             mem_wr;
        logic             mem_to_reg;
        logic             reg_wr;
        logic             is_lw;
        logic [2:0]       br;
        logic [RW_W-1:0]  rw;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // True when a stage writes a non-zero register that the reader is using.
    function automatic logic raw_hit(input logic rd_en, input logic [RW_W-1:0] r,
                                     input ctrl_t s);
        return rd_en && s.reg_wr && (s.rw != '0) && (s.rw == r);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational ID-stage decode: instruction -> control bundle,
//            sign-extend select, illegal flag and register read set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output ctrl_t             ctrl,
    output logic              ext_op,
    output logic              illegal,
    output logic              rd_rs,
    output logic              rd_rt,
    output logic [RW_W-1:0]   rs,
    output logic [RW_W-1:0]   rt
);

    logic [5:0]      w_op;
    logic [5:0]      w_fn;
    logic [RW_W-1:0] w_rd;
    ctrl_t           w_ctrl;
    logic            w_legal;
    logic            w_ext;
    logic            w_rd_rt;
    logic            w_ok;

    assign w_op = inst[31:26];
    assign rs   = inst[25:21];
    assign rt   = inst[20:16];
    assign w_rd = inst[15:11];
    assign w_fn = inst[5:0];

    always_comb begin
        w_ctrl  = CTRL_BUBBLE;
        w_legal = 1'b0;
        w_ext   = 1'b0;
        w_rd_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_legal        = 1'b1;
                w_ctrl.reg_dst = 1'b1;
                w_ctrl.reg_wr  = 1'b1;
                w_rd_rt        = 1'b1;
                case (w_fn)
                    FN_ADD:  w_ctrl.alu_ctr = ALUCTR_ADD;
                    FN_ADDU: w_ctrl.alu_ctr = ALUCTR_ADDU;
                    FN_SUB:  w_ctrl.alu_ctr = ALUCTR_SUB;
                    FN_SUBU: w_ctrl.alu_ctr = ALUCTR_SUB;
                    FN_AND:  w_ctrl.alu_ctr = ALUCTR_AND;
                    FN_OR:   w_ctrl.alu_ctr = ALUCTR_OR;
                    FN_SLL:  w_ctrl.alu_ctr = ALUCTR_SLL;
                    FN_SLT:  w_ctrl.alu_ctr = ALUCTR_SLT;
                    FN_SLTU: w_ctrl.alu_ctr = ALUCTR_SLTU;
                    default: w_legal        = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_legal        = 1'b1;
                w_ext          = 1'b1;
                w_ctrl.alu_src = 1'b1;
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_ctr = ALUCTR_ADD;
            end
            OP_LW: begin
                w_legal           = 1'b1;
                w_ext             = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.is_lw      = 1'b1;
                w_ctrl.alu_ctr    = ALUCTR_ADD;
            end
            OP_SW: begin
                w_legal        = 1'b1;
                w_ext          = 1'b1;
                w_rd_rt        = 1'b1;
                w_ctrl.alu_src = 1'b1;
                w_ctrl.mem_wr  = 1'b1;
                w_ctrl.alu_ctr = ALUCTR_ADD;
            end
            OP_BEQ: begin
                w_legal          = 1'b1;
                w_rd_rt          = 1'b1;
                w_ctrl.br[BR_EQ] = 1'b1;
                w_ctrl.alu_ctr   = ALUCTR_SUB;
            end
            OP_BNE: begin
                w_legal          = 1'b1;
                w_rd_rt          = 1'b1;
                w_ctrl.br[BR_NE] = 1'b1;
                w_ctrl.alu_ctr   = ALUCTR_SUB;
            end
            OP_BGTZ: begin
                // rt field is $0, so rs - rt yields the sign/zero of rs
                w_legal           = 1'b1;
                w_ctrl.br[BR_GTZ] = 1'b1;
                w_ctrl.alu_ctr    = ALUCTR_SUB;
            end
            default: w_legal = 1'b0;
        endcase
        w_ctrl.rw = w_ctrl.reg_dst ? w_rd : rt;
    end

    assign w_ok    = inst_valid & w_legal;
    assign ctrl    = w_ok ? w_ctrl : CTRL_BUBBLE;
    assign ext_op  = w_ok & w_ext;
    assign illegal = inst_valid & ~w_legal;
    assign rd_rs   = w_ok;
    assign rd_rt   = w_ok & w_rd_rt;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : 5-stage pipeline control/hazard unit: ID/EX, EX/MEM, MEM/WB control
//            registers, RAW/load-use stall, branch flush, WB bypass and optional
//            EX operand forwarding (enabled by defining FORWARDING_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int INST_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUCTR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INST_W-1:0]   inst_id,
    input  logic                inst_valid,
    input  logic                equal_ex,
    input  logic                sign_ex,
    output logic                ext_op_id,
    output logic                illegal_id,
    output logic                stall_if,
    output logic                flush,
    output logic                npc_sel_ex,
    output logic                reg_dst_ex,
    output logic                alu_src_ex,
    output logic [ALUCTR_W-1:0] alu_ctr_ex,
    output logic                mem_wr_mem,
    output logic                mem_to_reg_wb,
    output logic                reg_wr_wb,
    output logic [REG_AW-1:0]   rw_wb,
    output logic                id_byp_a,
    output logic                id_byp_b,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel
);

    ctrl_t           w_dec;
    logic            w_dec_ext;
    logic            w_dec_ill;
    logic            w_rd_rs;
    logic            w_rd_rt;
    logic [RW_W-1:0] w_rs;
    logic [RW_W-1:0] w_rt;

    ctrl_t r_idex;
    ctrl_t r_exmem;
    ctrl_t r_memwb;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hazard;
    logic w_taken;
    logic w_kill_id;

    ctrl_decode #(
        .INST_W (INST_W)
    ) u_decode (
        .inst       (inst_id),
        .inst_valid (inst_valid),
        .ctrl       (w_dec),
        .ext_op     (w_dec_ext),
        .illegal    (w_dec_ill),
        .rd_rs      (w_rd_rs),
        .rd_rt      (w_rd_rt),
        .rs         (w_rs),
        .rt         (w_rt)
    );

    assign w_hit_ex  = raw_hit(w_rd_rs, w_rs, r_idex)  | raw_hit(w_rd_rt, w_rt, r_idex);
    assign w_hit_mem = raw_hit(w_rd_rs, w_rs, r_exmem) | raw_hit(w_rd_rt, w_rt, r_exmem);

    assign w_taken = (r_idex.br[BR_EQ]  &  equal_ex)
                   | (r_idex.br[BR_NE]  & ~equal_ex)
                   | (r_idex.br[BR_GTZ] & ~(equal_ex | sign_ex));

`ifdef FORWARDING_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    assign w_hazard = r_idex.is_lw & w_hit_ex;

    // Selects are resolved in ID: today's EX becomes MEM and today's MEM becomes WB.
    always_comb begin
        w_fwd_a_nxt = 2'b00;
        w_fwd_b_nxt = 2'b00;
        if (raw_hit(w_rd_rs, w_rs, r_idex))       w_fwd_a_nxt = 2'b01;
        else if (raw_hit(w_rd_rs, w_rs, r_exmem)) w_fwd_a_nxt = 2'b10;
        if (raw_hit(w_rd_rt, w_rt, r_idex))       w_fwd_b_nxt = 2'b01;
        else if (raw_hit(w_rd_rt, w_rt, r_exmem)) w_fwd_b_nxt = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_kill_id) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    assign w_hazard  = w_hit_ex | w_hit_mem;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    assign w_kill_id = w_hazard | w_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex  <= CTRL_BUBBLE;
            r_exmem <= CTRL_BUBBLE;
            r_memwb <= CTRL_BUBBLE;
        end else begin
            r_idex  <= w_kill_id ? CTRL_BUBBLE : w_dec;
            r_exmem <= r_idex;
            r_memwb <= r_exmem;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign ext_op_id  = rst_n & w_dec_ext;
    assign illegal_id = rst_n & w_dec_ill;
    assign npc_sel_ex = rst_n & w_taken;
    assign flush      = rst_n & w_taken;
    assign stall_if   = rst_n & w_hazard & ~w_taken;
    assign id_byp_a   = rst_n & raw_hit(w_rd_rs, w_rs, r_memwb);
    assign id_byp_b   = rst_n & raw_hit(w_rd_rt, w_rt, r_memwb);

    assign reg_dst_ex    = r_idex.reg_dst;
    assign alu_src_ex    = r_idex.alu_src;
    assign alu_ctr_ex    = r_idex.alu_ctr;
    assign mem_wr_mem    = r_exmem.mem_wr;
    assign mem_to_reg_wb = r_memwb.mem_to_reg;
    assign reg_wr_wb     = r_memwb.reg_wr;
    assign rw_wb         = r_memwb.rw;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Self-checking bench for pipe_ctrl_unit (honours FORWARDING_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_id = '0;
    logic        inst_valid = 1'b0;
    logic        equal_ex = 1'b0;
    logic        sign_ex = 1'b0;
    logic        ext_op_id, illegal_id, stall_if, flush, npc_sel_ex;
    logic        reg_dst_ex, alu_src_ex, mem_wr_mem, mem_to_reg_wb, reg_wr_wb;
    logic [2:0]  alu_ctr_ex;
    logic [4:0]  rw_wb;
    logic        id_byp_a, id_byp_b;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .inst_valid(inst_valid),
        .equal_ex(equal_ex), .sign_ex(sign_ex), .ext_op_id(ext_op_id),
        .illegal_id(illegal_id), .stall_if(stall_if), .flush(flush),
        .npc_sel_ex(npc_sel_ex), .reg_dst_ex(reg_dst_ex), .alu_src_ex(alu_src_ex),
        .alu_ctr_ex(alu_ctr_ex), .mem_wr_mem(mem_wr_mem), .mem_to_reg_wb(mem_to_reg_wb),
        .reg_wr_wb(reg_wr_wb), .rw_wb(rw_wb), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    // Instruction set table: opcode, funct (R-type only), ALU control.
    bit [5:0] t_op [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h07};
    bit [5:0] t_fn [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2a, 6'h2b,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    bit [2:0] t_alu[15] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0, 3'd1, 3'd5, 3'd3, 3'd7,
                            3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd6};

    // One decoded instruction as it travels the pipe; all-zero means bubble.
    typedef struct packed {
        bit       legal, r, wr, lw, sw, imm, rd_rt;
        bit [1:0] br;       // 1 beq, 2 bne, 3 bgtz
        bit [2:0] alu;
        bit [4:0] rs, rt, dst;
    } m_t;

    m_t ex_s = '0, mem_s = '0, wb_s = '0;
    m_t cur_d;
    bit cur_rn, cur_kill;

    bit       e_ext, e_ill, e_stall, e_flush, e_rdst, e_asrc, e_mw, e_m2r, e_rw, e_ba, e_bb;
    bit [2:0] e_alu;
    bit [4:0] e_rwwb;
    bit [1:0] e_fa, e_fb;

    int n_chk = 0;
    int n_fail = 0;

    function automatic m_t m_decode(bit [31:0] i, bit v);
        m_t d = '0;
        int k = -1;
        for (int j = 0; j < 15; j++)
            if (t_op[j] == i[31:26] && (t_op[j] != 6'h00 || t_fn[j] == i[5:0])) k = j;
        if (!v || k < 0) return d;
        d.legal = 1;
        d.alu   = t_alu[k];
        d.r     = (i[31:26] == 6'h00);
        d.rs    = i[25:21];
        d.rt    = i[20:16];
        d.dst   = d.r ? i[15:11] : i[20:16];
        d.lw    = (i[31:26] == 6'h23);
        d.sw    = (i[31:26] == 6'h2b);
        d.wr    = d.r || d.lw || (i[31:26] == 6'h08);
        d.imm   = d.lw || d.sw || (i[31:26] == 6'h08);
        d.br    = (i[31:26] == 6'h04) ? 2'd1 : (i[31:26] == 6'h05) ? 2'd2 :
                  (i[31:26] == 6'h07) ? 2'd3 : 2'd0;
        d.rd_rt = d.r || d.sw || d.br == 2'd1 || d.br == 2'd2;
        return d;
    endfunction

    function automatic bit wrt(m_t s, bit [4:0] r);
        return s.wr && s.dst != 0 && s.dst == r;
    endfunction

    function automatic bit [31:0] rtype(bit [5:0] fn, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic bit [31:0] itype(bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one ID-stage cycle, predict all outputs and compare.
    task automatic cyc(input bit [31:0] i, input bit v, input bit eq, input bit sg, input bit rn);
        bit taken, hit_ex, hit_mem, haz, ra, rb;
        @(negedge clk);
        inst_id = i; inst_valid = v; equal_ex = eq; sign_ex = sg; rst_n = rn;
        cur_d  = m_decode(i, v);
        cur_rn = rn;
        ra = cur_d.legal;
        rb = cur_d.rd_rt;
        taken   = (ex_s.br == 1 && eq) || (ex_s.br == 2 && !eq) || (ex_s.br == 3 && !(eq || sg));
        hit_ex  = (ra && wrt(ex_s, cur_d.rs))  || (rb && wrt(ex_s, cur_d.rt));
        hit_mem = (ra && wrt(mem_s, cur_d.rs)) || (rb && wrt(mem_s, cur_d.rt));
        haz     = FWD ? (ex_s.lw && hit_ex) : (hit_ex || hit_mem);
        cur_kill = haz || taken;
        e_flush = rn && taken;
        e_stall = rn && haz && !taken;
        e_ext   = rn && cur_d.imm;
        e_ill   = rn && v && !cur_d.legal;
        e_ba    = rn && ra && wrt(wb_s, cur_d.rs);
        e_bb    = rn && rb && wrt(wb_s, cur_d.rt);
        e_rdst  = ex_s.r;
        e_asrc  = ex_s.imm;
        e_alu   = ex_s.alu;
        e_mw    = mem_s.sw;
        e_m2r   = wb_s.lw;
        e_rw    = wb_s.wr;
        e_rwwb  = wb_s.dst;
        e_fa = 0;
        e_fb = 0;
        if (FWD) begin
            e_fa = (ex_s.legal && wrt(mem_s, ex_s.rs)) ? 2'd1 : (ex_s.legal && wrt(wb_s, ex_s.rs)) ? 2'd2 : 2'd0;
            e_fb = (ex_s.rd_rt && wrt(mem_s, ex_s.rt)) ? 2'd1 : (ex_s.rd_rt && wrt(wb_s, ex_s.rt)) ? 2'd2 : 2'd0;
        end
        #1;
        chk("ext_op_id", ext_op_id, e_ext);
        chk("illegal_id", illegal_id, e_ill);
        chk("stall_if", stall_if, e_stall);
        chk("flush", flush, e_flush);
        chk("npc_sel_ex", npc_sel_ex, e_flush);
        chk("reg_dst_ex", reg_dst_ex, e_rdst);
        chk("alu_src_ex", alu_src_ex, e_asrc);
        chk("alu_ctr_ex", alu_ctr_ex, e_alu);
        chk("mem_wr_mem", mem_wr_mem, e_mw);
        chk("mem_to_reg_wb", mem_to_reg_wb, e_m2r);
        chk("reg_wr_wb", reg_wr_wb, e_rw);
        chk("rw_wb", rw_wb, e_rwwb);
        chk("id_byp_a", id_byp_a, e_ba);
        chk("id_byp_b", id_byp_b, e_bb);
        chk("fwd_a_sel", fwd_a_sel, e_fa);
        chk("fwd_b_sel", fwd_b_sel, e_fb);
    endtask

    task automatic adv();
        @(posedge clk);
        if (!cur_rn) begin
            ex_s = '0; mem_s = '0; wb_s = '0;
        end else begin
            wb_s  = mem_s;
            mem_s = ex_s;
            ex_s  = cur_kill ? m_t'('0) : cur_d;
        end
    endtask

    task automatic nop();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();
    endtask

    // Present an instruction in ID until it is accepted; reports stall cycles.
    task automatic issue(input bit [31:0] i, output int stalls);
        stalls = 0;
        for (int t = 0; t < 5; t++) begin
            cyc(i, 1'b1, 1'b0, 1'b0, 1'b1);
            adv();
            if (!e_stall) return;
            stalls++;
        end
        n_chk++;
        n_fail++;
        $display("FAIL issue_bound: got %0d stall cycles expected at most 4", stalls);
    endtask

    initial begin
        int st;
        bit [31:0] ri;
        bit rv, p_stall, p_flush;

        // 1: reset with add $3,$1,$2 in ID, then write-back three cycles later
        for (int k = 0; k < 3; k++) begin
            cyc(rtype(6'h20, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("reset_all_zero", {ext_op_id, illegal_id, stall_if, flush, npc_sel_ex, reg_dst_ex,
                alu_src_ex, alu_ctr_ex, mem_wr_mem, mem_to_reg_wb, reg_wr_wb, rw_wb, id_byp_a,
                id_byp_b, fwd_a_sel, fwd_b_sel}, 32'h0);
            adv();
        end
        issue(rtype(6'h20, 1, 2, 3), st);
        nop();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_reg_wr_early", reg_wr_wb, 1'b0);
        adv();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_reg_wr_wb", reg_wr_wb, 1'b1);
        chk("t1_rw_wb", rw_wb, 5'd3);
        adv();

        // 2: load-use
        issue(itype(6'h23, 1, 4, 16'h0), st);
        issue(rtype(6'h20, 4, 4, 5), st);
        chk("t2_stall_cycles", st, FWD ? 1 : 2);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_fwd_a", fwd_a_sel, FWD ? 2'b10 : 2'b00);
        chk("t2_fwd_b", fwd_b_sel, FWD ? 2'b10 : 2'b00);
        adv();
        repeat (3) nop();

        // 3: ALU RAW
        issue(rtype(6'h20, 1, 2, 6), st);
        issue(rtype(6'h22, 6, 6, 7), st);
        chk("t3_stall_cycles", st, FWD ? 0 : 2);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_fwd_a", fwd_a_sel, FWD ? 2'b01 : 2'b00);
        chk("t3_fwd_b", fwd_b_sel, FWD ? 2'b01 : 2'b00);
        adv();
        repeat (3) nop();

        // 4: taken beq squashes the sw behind it
        issue(itype(6'h04, 1, 2, 16'h4), st);
        cyc(itype(6'h2b, 1, 3, 16'h0), 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_npc_sel", npc_sel_ex, 1'b1);
        chk("t4_flush", flush, 1'b1);
        adv();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_npc_one_cycle", npc_sel_ex, 1'b0);
        adv();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_sw_squashed", mem_wr_mem, 1'b0);
        adv();
        repeat (3) nop();

        // 5: pending RAW stall coinciding with a taken branch
        issue(itype(6'h23, 1, 4, 16'h0), st);
        issue(itype(6'h04, 1, 2, 16'h4), st);
        cyc(rtype(6'h20, 4, 4, 5), 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_flush", flush, 1'b1);
        chk("t5_no_stall", stall_if, 1'b0);
        adv();
        repeat (4) nop();

        // 6: illegal opcode and writes to $0
        cyc(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_illegal", illegal_id, 1'b1);
        adv();
        issue(rtype(6'h20, 1, 2, 0), st);
        issue(rtype(6'h20, 0, 0, 9), st);
        chk("t6_zero_no_stall", st, 0);
        repeat (4) nop();

        // Random traffic; the bench acts as the fetch stage.
        p_stall = 0;
        p_flush = 0;
        ri = 0;
        rv = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!p_stall) begin
                int k = $urandom_range(0, 15);
                bit [4:0] a = 5'($urandom_range(0, 7));
                bit [4:0] b = 5'($urandom_range(0, 7));
                bit [4:0] c = 5'($urandom_range(0, 7));
                if (k == 15)
                    ri = ($urandom_range(0, 1) == 0) ? 32'hFC00_0000 | 32'($urandom_range(0, 65535))
                                                     : rtype(6'h08, a, b, c);
                else if (t_op[k] == 6'h00)
                    ri = rtype(t_fn[k], a, b, c) | (32'($urandom_range(0, 31)) << 6);
                else
                    ri = itype(t_op[k], a, (t_op[k] == 6'h07) ? 5'd0 : b, 16'($urandom));
                rv = !p_flush && ($urandom_range(0, 9) != 0);
            end
            cyc(ri, rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) != 0);
            p_stall = e_stall;
            p_flush = e_flush;
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
